// File: rtl/fetch_queue_stage.sv
// -----------------------------------------------------------------------------
// fetch_queue_stage
//   Instruction fetch stage feeding issue/decode. Owns the fetch PC, issues
//   64-bit aligned instruction-memory loads, picks the 32-bit instruction out of
//   each returned word and buffers it in a small circular fetch queue whose
//   head is presented to issue as an IF_ID_PACKET.
//
//   Optional feature macro: FQ_BYPASS_EN
//     defined   : an instruction fetched into an empty queue, with issue not
//                 stalled, goes straight to the output in the same cycle and
//                 is never written to the queue.
//     undefined : every instruction passes through the queue (1-cycle minimum
//                 fetch-to-issue latency).
//
// Ports
//   clock              system clock
//   reset              asynchronous active-low reset
//   stall              issue cannot accept the head packet this cycle
//   redirect_en        flush the queue and refetch from redirect_pc
//   redirect_pc        new fetch PC; bits [1:0] are ignored
//   Imem2proc_data     64-bit instruction-memory read data
//   Imem2proc_valid    read data valid this cycle
//   proc2Imem_command  BUS_LOAD while fetching, else BUS_NONE
//   proc2Imem_addr     8-byte aligned fetch address
//   if_id_packet_out   head entry {inst, PC, NPC, valid}
//   fq_count           current queue occupancy
// -----------------------------------------------------------------------------
`ifndef XLEN
`define XLEN 32
`endif
`ifndef NOP
`define NOP 32'h00000013
`endif
`ifndef WFI
`define WFI 32'h10500073
`endif

package fetch_queue_pkg;
  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } BUS_COMMAND;

  typedef struct packed {
    logic [31:0]       inst;
    logic [`XLEN-1:0]  PC;
    logic [`XLEN-1:0]  NPC;
    logic              valid;
  } IF_ID_PACKET;
endpackage

module fetch_queue_stage
  import fetch_queue_pkg::*;
#(
  parameter int               FQ_DEPTH = 4,
  parameter logic [`XLEN-1:0] RESET_PC = 32'h0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    stall,
  input  logic                    redirect_en,
  input  logic [`XLEN-1:0]        redirect_pc,
  input  logic [63:0]             Imem2proc_data,
  input  logic                    Imem2proc_valid,
  output BUS_COMMAND              proc2Imem_command,
  output logic [`XLEN-1:0]        proc2Imem_addr,
  output IF_ID_PACKET             if_id_packet_out,
  output logic [$clog2(FQ_DEPTH):0] fq_count
);

  localparam int PW = $clog2(FQ_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FQ_DEPTH);
  localparam logic [CW-1:0] ZERO_C  = {CW{1'b0}};

  // Queue state; count is kept apart from the pointers so full/empty never alias.
  logic [`XLEN-1:0] fetch_pc_r;
  logic [PW-1:0]    head_r;
  logic [PW-1:0]    tail_r;
  logic [CW-1:0]    count_r;
  logic             halted_r;
  logic [31:0]      inst_mem_r [FQ_DEPTH];
  logic [`XLEN-1:0] pc_mem_r   [FQ_DEPTH];

  logic             queued_valid_s;
  logic             deq_s;
  logic             fetch_req_s;
  logic             enq_s;
  logic             bypass_s;
  logic             write_s;
  logic [31:0]      fetched_inst_s;
  logic [CW-1:0]    count_next_s;
  logic [`XLEN-1:0] redirect_pc_aligned_s;

  function automatic logic is_wfi(input logic [31:0] inst);
    return inst == `WFI;
  endfunction

  // Handshake decode: fetch request, enqueue, dequeue and bypass.
  always_comb begin
    // reset gates everything so the outputs stay idle while reset is held
    queued_valid_s = reset & ~redirect_en & (count_r != ZERO_C);
    deq_s          = queued_valid_s & ~stall;
    // a full queue may still fetch when the head leaves in the same cycle
    fetch_req_s    = reset & ~halted_r & ~redirect_en &
                     ((count_r < DEPTH_C) | deq_s);
    enq_s          = fetch_req_s & Imem2proc_valid;
    fetched_inst_s = fetch_pc_r[2] ? Imem2proc_data[63:32] : Imem2proc_data[31:0];
`ifdef FQ_BYPASS_EN
    // redirect_en already suppresses enq_s
    bypass_s       = enq_s & (count_r == ZERO_C) & ~stall;
`else
    bypass_s       = 1'b0;
`endif
    write_s        = enq_s & ~bypass_s;
    count_next_s   = count_r + CW'(write_s) - CW'(deq_s);
    redirect_pc_aligned_s = redirect_pc & {{(`XLEN-2){1'b1}}, 2'b00};
  end

  // Output packet and memory request.
  always_comb begin
    if_id_packet_out.inst  = `NOP;
    if_id_packet_out.PC    = {`XLEN{1'b0}};
    if_id_packet_out.NPC   = {`XLEN{1'b0}};
    if_id_packet_out.valid = 1'b0;
    if (bypass_s) begin
      if_id_packet_out.inst  = fetched_inst_s;
      if_id_packet_out.PC    = fetch_pc_r;
      if_id_packet_out.NPC   = fetch_pc_r + `XLEN'(4);
      if_id_packet_out.valid = 1'b1;
    end else if (count_r != ZERO_C) begin
      if_id_packet_out.inst  = inst_mem_r[head_r];
      if_id_packet_out.PC    = pc_mem_r[head_r];
      if_id_packet_out.NPC   = pc_mem_r[head_r] + `XLEN'(4);
      if_id_packet_out.valid = queued_valid_s;
    end else begin
      if_id_packet_out.valid = 1'b0;
    end
    proc2Imem_command = fetch_req_s ? BUS_LOAD : BUS_NONE;
    proc2Imem_addr    = {fetch_pc_r[`XLEN-1:3], 3'b000};
    fq_count          = count_r;
  end

  // Control state: fetch PC, pointers, occupancy and halt flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc_r <= RESET_PC;
      head_r     <= {PW{1'b0}};
      tail_r     <= {PW{1'b0}};
      count_r    <= ZERO_C;
      halted_r   <= 1'b0;
    end else if (redirect_en) begin
      fetch_pc_r <= redirect_pc_aligned_s;
      head_r     <= {PW{1'b0}};
      tail_r     <= {PW{1'b0}};
      count_r    <= ZERO_C;
      halted_r   <= 1'b0;
    end else begin
      if (enq_s) begin
        fetch_pc_r <= fetch_pc_r + `XLEN'(4);
      end
      if (write_s) begin
        tail_r <= tail_r + PW'(1);
      end
      if (deq_s) begin
        head_r <= head_r + PW'(1);
      end
      count_r <= count_next_s;
      // the WFI itself is still queued/issued; only later fetches stop
      if (enq_s && is_wfi(fetched_inst_s)) begin
        halted_r <= 1'b1;
      end
    end
  end

  // Queue storage; contents are qualified by count so it needs no reset.
  always_ff @(posedge clock) begin
    if (write_s) begin
      inst_mem_r[tail_r] <= fetched_inst_s;
      pc_mem_r[tail_r]   <= fetch_pc_r;
    end
  end

endmodule
